tea_operand_loader: RTL
=======================

// Module: tea_operand_loader
// PURPOSE
//  Upstream stage of the TEA cipher core. Assembles the six 32-bit operands (v0,v1,k0,k1,k2,k3)
//  from byte-wide switch entry, one byte per debounced KEY press. Presents the full operand set
//  to the core over a valid/ready handshake, replacing the core's 10-bit direct loads.
//  Drives preview/index outputs so the board display shows entry progress.
// PARAMETERS
//  DEBOUNCE_CYCLES  16'd50000  cycles go_n must be stable before a level change is accepted (1 ms @ 50 MHz)
//  KEEP_KEY         1'b1       1: after a handshake, only v0,v1 are re-entered; k0..k3 are retained
// PORTS
//  clk        in   1   system clock (CLOCK_50)
//  resetn     in   1   synchronous, active-low reset
//  go_n       in   1   raw push-button, active-low, asynchronous to clk
//  data_in    in   8   byte to capture (SW[7:0]); sampled only on an accepted press
//  clear      in   1   synchronous restart of entry; single-cycle or level
//  out_ready  in   1   core ready to take the operand set
//  out_valid  out  1   full operand set held and stable
//  v0,v1      out  32  plaintext/ciphertext words
//  k0..k3     out  32  key words
//  word_idx   out  3   word being entered (0=v0 .. 5=k3); 6 when full
//  byte_idx   out  2   next byte position within the current word (0 = MSB)
//  preview    out  32  partially assembled current word, for hex display
//  overrun    out  1   sticky: a press occurred while out_valid was high
// BEHAVIOUR
//  Reset: all operand registers, preview, word_idx, byte_idx, overrun, out_valid = 0; FSM -> COLLECT.
//  Input conditioning: go_n -> 2-FF synchroniser -> debouncer. The debounced level changes only
//   after DEBOUNCE_CYCLES consecutive equal samples. go_pulse = 1 for exactly one cycle on each
//   debounced press (high->low of go_n). One physical press yields exactly one pulse, with no
//   repeat while the button is held.
//  FSM states:
//   COLLECT: on go_pulse, shift preview <= {preview[23:0], data_in} and increment byte_idx.
//     When byte_idx==3, write {preview[23:0], data_in} into operand[word_idx], clear preview,
//     set byte_idx=0, increment word_idx.
//     When word_idx==5 && byte_idx==3, the entered word completes the set -> FULL.
//   FULL: out_valid=1, word_idx=6, operands frozen.
//     When out_valid && out_ready, the handshake completes on that edge: out_valid -> 0, overrun -> 0,
//     FSM -> COLLECT with word_idx=0, byte_idx=0.
//     If KEEP_KEY=1: k0..k3 are retained and the set is FULL again after v1 completes (word_idx==1,
//     byte_idx==3). If KEEP_KEY=0: all six words are re-entered, and the operands are zeroed.
//     A go_pulse in FULL is ignored for data and sets overrun, including when out_ready is high the same cycle.
//  Byte order: big-endian; the first byte entered becomes bits [31:24].
//  Operand order: v0, v1, k0, k1, k2, k3.
//  clear: highest priority after reset. Returns the FSM to COLLECT with word_idx=0, byte_idx=0,
//   preview=0, out_valid=0 and overrun=0. Operands are zeroed, except k0..k3 when KEEP_KEY=1 and
//   a key is already held. clear together with go_pulse: clear wins and the byte is discarded.
//  out_valid never depends combinationally on out_ready. Operands do not change while out_valid=1.
//  Press-to-capture latency: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles from a stable go_n fall.
// STRUCTURE
//  tea_pkg: word-index constants (W_V0=0 .. W_K3=5, W_FULL=6), FSM state encoding, and TEA_WORD_W=32.
//   The cipher core shares this package.
//  Sub-module key_debouncer (synchroniser + stable counter + falling-edge pulse), parameter DEBOUNCE_CYCLES.
//   It is reused for the core's mode/start key.
//  Operand storage: 6 x 32-bit register array indexed by word_idx, broken out to the named ports.
// TESTING (DEBOUNCE_CYCLES=4 in simulation)
//  1. Enter bytes 01,23,45,67 ... 24 bytes -> v0=32'h01234567, v1..k3 as entered, out_valid=1, word_idx=6.
//  2. Bounce go_n (toggles every 2 cycles for 10 cycles, then held low) -> exactly one byte captured, byte_idx 0->1.
//  3. KEEP_KEY=1: after the handshake, enter 8 bytes AA..B1 -> out_valid=1, v0=32'hAAABACAD,
//     v1=32'hAEAFB0B1, k0..k3 unchanged.
//  4. In FULL, press go with out_ready=0 -> operands unchanged, overrun=1. Assert out_ready -> out_valid=0,
//     overrun=0 after 1 edge.
//  5. After 13 bytes, pulse clear together with go_pulse -> word_idx=0, byte_idx=0, preview=0, byte discarded.
//  6. Assert resetn=0 for 1 cycle at word_idx=3 -> all outputs 0 on the next edge. A following press
//     captures into v0[31:24].

Source files
------------

// File: rtl/tea_pkg.sv
// Shared TEA definitions: word width, operand index constants and loader FSM encoding.
// Used by the operand loader and the cipher core.
package tea_pkg;

  localparam int unsigned TEA_WORD_W    = 32;
  localparam int unsigned TEA_NUM_WORDS = 6;
  localparam int unsigned WORD_IDX_W    = 3;
  localparam int unsigned BYTE_IDX_W    = 2;

  localparam logic [WORD_IDX_W-1:0] W_V0   = 3'd0;
  localparam logic [WORD_IDX_W-1:0] W_V1   = 3'd1;
  localparam logic [WORD_IDX_W-1:0] W_K0   = 3'd2;
  localparam logic [WORD_IDX_W-1:0] W_K1   = 3'd3;
  localparam logic [WORD_IDX_W-1:0] W_K2   = 3'd4;
  localparam logic [WORD_IDX_W-1:0] W_K3   = 3'd5;
  localparam logic [WORD_IDX_W-1:0] W_FULL = 3'd6;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } ld_state_e;

  // Big-endian byte accumulation: earlier bytes move toward the MSB.
  function automatic logic [TEA_WORD_W-1:0] shift_in_byte(input logic [TEA_WORD_W-1:0] w,
                                                          input logic [7:0]            b);
    return {w[TEA_WORD_W-9:0], b};
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stable-sample counter, and a
// one-cycle pulse on each accepted press (debounced high->low of the active-low key).
module key_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n_i,
  output logic press_o
);

  logic [1:0]  sync_q;
  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;
  logic        press_q, press_d;
  logic        key_s;

  assign key_s   = sync_q[1];
  assign press_o = press_q;

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (key_s != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        level_d = key_s;
        press_d = ~key_s;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

endmodule

// File: rtl/tea_operand_loader.sv
// Assembles the six TEA operand words from byte-wide switch entry, one byte per
// debounced key press, and offers the full set to the core over valid/ready.
module tea_operand_loader
  import tea_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter bit          KEEP_KEY        = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  go_n,
  input  logic [7:0]            data_in,
  input  logic                  clear,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [TEA_WORD_W-1:0] v0,
  output logic [TEA_WORD_W-1:0] v1,
  output logic [TEA_WORD_W-1:0] k0,
  output logic [TEA_WORD_W-1:0] k1,
  output logic [TEA_WORD_W-1:0] k2,
  output logic [TEA_WORD_W-1:0] k3,
  output logic [WORD_IDX_W-1:0] word_idx,
  output logic [BYTE_IDX_W-1:0] byte_idx,
  output logic [TEA_WORD_W-1:0] preview,
  output logic                  overrun
);

  logic go_pulse;

  ld_state_e             state_q, state_d;
  logic [WORD_IDX_W-1:0] word_idx_q, word_idx_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [TEA_WORD_W-1:0] preview_q, preview_d;
  logic [TEA_WORD_W-1:0] ops_q [TEA_NUM_WORDS];
  logic [TEA_WORD_W-1:0] ops_d [TEA_NUM_WORDS];
  logic                  overrun_q, overrun_d;
  logic                  out_valid_q, out_valid_d;
  logic                  key_held_q, key_held_d;
  logic                  last_word_c;
  logic                  keep_keys_c;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_go_db (
    .clk    (clk),
    .resetn (resetn),
    .key_n_i(go_n),
    .press_o(go_pulse)
  );

  // With a retained key, the set completes after v1 instead of k3.
  assign keep_keys_c = KEEP_KEY && key_held_q;
  assign last_word_c = (word_idx_q == W_K3) || (keep_keys_c && (word_idx_q == W_V1));

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_COLLECT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_COLLECT;
    end else begin
      case (state_q)
        ST_COLLECT: if (go_pulse && (byte_idx_q == 2'd3) && last_word_c) state_d = ST_FULL;
        ST_FULL:    if (out_ready) state_d = ST_COLLECT;
        default:    state_d = ST_COLLECT;
      endcase
    end
  end

  always_comb begin
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    preview_d   = preview_q;
    ops_d       = ops_q;
    overrun_d   = overrun_q;
    out_valid_d = out_valid_q;
    key_held_d  = key_held_q;
    if (clear) begin
      word_idx_d  = W_V0;
      byte_idx_d  = '0;
      preview_d   = '0;
      overrun_d   = 1'b0;
      out_valid_d = 1'b0;
      key_held_d  = keep_keys_c;
      for (int i = 0; i < int'(TEA_NUM_WORDS); i++) begin
        if ((i < int'(W_K0)) || !keep_keys_c) ops_d[i] = '0;
      end
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (go_pulse) begin
            if (byte_idx_q == 2'd3) begin
              for (int i = 0; i < int'(TEA_NUM_WORDS); i++) begin
                if (word_idx_q == 3'(i)) ops_d[i] = shift_in_byte(preview_q, data_in);
              end
              preview_d  = '0;
              byte_idx_d = '0;
              if (last_word_c) begin
                word_idx_d  = W_FULL;
                out_valid_d = 1'b1;
                key_held_d  = 1'b1;
              end else begin
                word_idx_d = word_idx_q + 3'd1;
              end
            end else begin
              preview_d  = shift_in_byte(preview_q, data_in);
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end
        ST_FULL: begin
          // A press here never enters data; it is only flagged, and the flag survives a same-cycle handshake.
          if (out_ready) begin
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
            word_idx_d  = W_V0;
            byte_idx_d  = '0;
            if (!KEEP_KEY) begin
              key_held_d = 1'b0;
              for (int i = 0; i < int'(TEA_NUM_WORDS); i++) ops_d[i] = '0;
            end
          end
          if (go_pulse) overrun_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_idx_q  <= W_V0;
      byte_idx_q  <= '0;
      preview_q   <= '0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      for (int i = 0; i < int'(TEA_NUM_WORDS); i++) ops_q[i] <= '0;
    end else begin
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      preview_q   <= preview_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      key_held_q  <= key_held_d;
      ops_q       <= ops_d;
    end
  end

  assign out_valid = out_valid_q;
  assign word_idx  = word_idx_q;
  assign byte_idx  = byte_idx_q;
  assign preview   = preview_q;
  assign overrun   = overrun_q;
  assign v0        = ops_q[W_V0];
  assign v1        = ops_q[W_V1];
  assign k0        = ops_q[W_K0];
  assign k1        = ops_q[W_K1];
  assign k2        = ops_q[W_K2];
  assign k3        = ops_q[W_K3];

endmodule
